// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: pushbutton/tick inputs and strobe/display outputs of the set controller
interface clock_set_ctrl_if;
  logic key_mode_n, key_inc_n, tick_in;
  logic tick_out, inc_hr, inc_min, sec_clr, blank_hr, blank_min;
  logic [1:0] mode;
  modport master (output key_mode_n, key_inc_n, tick_in,
                  input tick_out, inc_hr, inc_min, sec_clr, mode, blank_hr, blank_min);
  modport slave (input key_mode_n, key_inc_n, tick_in,
                 output tick_out, inc_hr, inc_min, sec_clr, mode, blank_hr, blank_min);
endinterface

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: RUN/SET_HR/SET_MIN sequencer with key sync, auto-repeat increments,
// 1 Hz tick gating and field blink for the HH:MM:SS clock.
module clock_set_ctrl #(
  parameter int BLINK_HALF = 25000000,
  parameter int RPT_DELAY = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input logic clk,
  input logic rst,
  clock_set_ctrl_if.slave io
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10, BAD = 2'b11} mode_e;
  localparam int RMAX = RPT_DELAY > RPT_PERIOD ? RPT_DELAY : RPT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  mode_e mode_q, mode_d;
  logic [2:0] msync_q, msync_d, isync_q, isync_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic armed_q, armed_d, rep_q, rep_d, phase_q, phase_d;
  logic tick_q, tick_d, hr_q, hr_d, min_q, min_d, clr_q, clr_d, bhr_q, bhr_d, bmin_q, bmin_d;
  logic m_press, i_press, i_low, in_set, rpt_hit, hold, fire, enter, bwrap;
  always_comb begin
    // bit0 = 1st sync flop, bit1 = 2nd sync flop, bit2 = edge register
    msync_d = {msync_q[1:0], io.key_mode_n};
    isync_d = {isync_q[1:0], io.key_inc_n};
    m_press = msync_q[2] & ~msync_q[1];
    i_press = isync_q[2] & ~isync_q[1];
    i_low = ~isync_q[1];
    in_set = mode_q == SET_HR || mode_q == SET_MIN;
    rpt_hit = armed_q && rcnt_q == (rep_q ? RW'(RPT_PERIOD) : RW'(RPT_DELAY));
    // repeat is armed only by a real press in a SET state; a MODE press cancels it
    hold = in_set && i_low && !m_press && (i_press || armed_q);
    fire = hold && (i_press || rpt_hit);
    armed_d = hold;
    rep_d = hold && (rep_q || rpt_hit);
    rcnt_d = !hold ? '0 : rpt_hit ? RW'(1) : rcnt_q + 1'b1;
    mode_d = mode_q == BAD ? RUN : !m_press ? mode_q : mode_q == RUN ? SET_HR :
             mode_q == SET_HR ? SET_MIN : RUN;
    enter = mode_d != mode_q && mode_d != RUN;
    bwrap = bcnt_q == BW'(BLINK_HALF - 1);
    bcnt_d = (enter || bwrap) ? '0 : bcnt_q + 1'b1;
    phase_d = !enter && (phase_q ^ bwrap);
    tick_d = io.tick_in && mode_q == RUN;
    hr_d = fire && mode_q == SET_HR;
    min_d = fire && mode_q == SET_MIN;
    clr_d = m_press && mode_q == SET_MIN;
    bhr_d = mode_d == SET_HR && phase_d;
    bmin_d = mode_d == SET_MIN && phase_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= RUN;
      msync_q <= '1;
      isync_q <= '1;
      rcnt_q <= '0;
      bcnt_q <= '0;
      armed_q <= 1'b0;
      rep_q <= 1'b0;
      phase_q <= 1'b0;
      tick_q <= 1'b0;
      hr_q <= 1'b0;
      min_q <= 1'b0;
      clr_q <= 1'b0;
      bhr_q <= 1'b0;
      bmin_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      msync_q <= msync_d;
      isync_q <= isync_d;
      rcnt_q <= rcnt_d;
      bcnt_q <= bcnt_d;
      armed_q <= armed_d;
      rep_q <= rep_d;
      phase_q <= phase_d;
      tick_q <= tick_d;
      hr_q <= hr_d;
      min_q <= min_d;
      clr_q <= clr_d;
      bhr_q <= bhr_d;
      bmin_q <= bmin_d;
    end
  end
  assign io.mode = mode_q;
  assign io.tick_out = tick_q;
  assign io.inc_hr = hr_q;
  assign io.inc_min = min_q;
  assign io.sec_clr = clr_q;
  assign io.blank_hr = bhr_q;
  assign io.blank_min = bmin_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scenario tasks plus randomized run, each cycle compared to a
// press-time/arithmetic reference model of the set controller.
`timescale 1ps/1ps
module tb_clock_set_ctrl;
  localparam int BH = 4, RD = 8, RP = 3;
  logic clk = 1'b0, rst = 1'b0;
  int errors = 0, checks = 0;
  clock_set_ctrl_if io();
  clock_set_ctrl #(.BLINK_HALF(BH), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  bit [3:0] mh, ih;
  int t, inc_start, enter_t, m_mode;
  logic [7:0] exp_v;
  function automatic logic [7:0] obs();
    return {io.mode, io.tick_out, io.inc_hr, io.inc_min, io.sec_clr, io.blank_hr, io.blank_min};
  endfunction
  task automatic model_reset();
    mh = '1; ih = '1; t = 0; inc_start = -1; enter_t = 0; m_mode = 0; exp_v = '0;
  endtask
  // levels sampled at edge t: a press becomes visible at edge t when key(t-2)=0 and key(t-3)=1
  task automatic model_step(input bit km, input bit ki, input bit ti);
    int old, nw, d;
    bit mp, ip, il, fire, bh, bm;
    t++;
    mh = {mh[2:0], km};
    ih = {ih[2:0], ki};
    mp = !mh[2] && mh[3];
    ip = !ih[2] && ih[3];
    il = !ih[2];
    old = m_mode;
    fire = 0;
    if (mp || old == 0 || !il) inc_start = -1;
    else if (ip) begin fire = 1; inc_start = t; end
    else if (inc_start >= 0) begin
      d = t - inc_start;
      fire = d == RD || (d > RD && (d - RD) % RP == 0);
    end
    nw = mp ? (old + 1) % 3 : old;
    if (nw != old && nw != 0) enter_t = t;
    bh = nw == 1 && ((t - enter_t) / BH) % 2 == 1;
    bm = nw == 2 && ((t - enter_t) / BH) % 2 == 1;
    m_mode = nw;
    exp_v = {2'(nw), ti && old == 0, fire && old == 1, fire && old == 2, mp && old == 2, bh, bm};
  endtask
  task automatic cyc(input bit km, input bit ki, input bit ti);
    io.key_mode_n = km; io.key_inc_n = ki; io.tick_in = ti;
    @(posedge clk);
    model_step(km, ki, ti);
    @(negedge clk);
  endtask
  task automatic test_reset();
    io.key_mode_n = 1; io.key_inc_n = 1; io.tick_in = 0;
    #1 rst = 1;
    #11;
    checks++;
    if (obs() !== 8'h00) begin errors++; $display("FAIL reset_state got=%b exp=%b", obs(), 8'h00); end
    @(negedge clk); rst = 0; model_reset();
    repeat (4) begin
      cyc(1, 1, 0);
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL reset_idle t=%0d got=%b exp=%b", t, obs(), exp_v); end
    end
  endtask
  task automatic test_mode_steps();
    int nclr = 0;
    repeat (2) begin
      repeat (2) begin
        cyc(0, 1, 0); nclr += io.sec_clr; checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL mode_step t=%0d got=%b exp=%b", t, obs(), exp_v); end
      end
      repeat (4) begin
        cyc(1, 1, 0); nclr += io.sec_clr; checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL mode_step t=%0d got=%b exp=%b", t, obs(), exp_v); end
      end
    end
    checks++;
    if (io.mode !== 2'b10 || nclr != 0) begin errors++; $display("FAIL mode_final mode=%b clr=%0d exp mode=10 clr=0", io.mode, nclr); end
  endtask
  task automatic test_inc_min();
    int nmin = 0, nhr = 0, ntick = 0;
    for (int i = 0; i < 33; i++) begin
      cyc(1, (i % 2 == 1) || i >= 30, 1'($urandom_range(0, 1)));
      nmin += io.inc_min; nhr += io.inc_hr; ntick += io.tick_out; checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL inc_min t=%0d got=%b exp=%b", t, obs(), exp_v); end
    end
    checks++;
    if (nmin != 15 || nhr != 0 || ntick != 0) begin
      errors++; $display("FAIL inc_min_count min=%0d hr=%0d tick=%0d exp 15 0 0", nmin, nhr, ntick);
    end
  endtask
  task automatic test_exit_run();
    int nclr = 0, nin = 0, nout = 0;
    for (int i = 0; i < 14; i++) begin
      bit ti;
      ti = i >= 5 && i < 13 && $urandom_range(0, 1) == 1;
      nin += ti;
      cyc(i >= 2, 1, ti);
      nclr += io.sec_clr; nout += io.tick_out; checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL exit_run t=%0d got=%b exp=%b", t, obs(), exp_v); end
    end
    checks++;
    if (nclr != 1 || io.mode !== 2'b00 || nout != nin) begin
      errors++; $display("FAIL exit_run_sum clr=%0d mode=%b ticks=%0d exp clr=1 mode=00 ticks=%0d", nclr, io.mode, nout, nin);
    end
  endtask
  task automatic test_hold();
    int p0;
    int got[$];
    int want[$];
    want = {2, 2 + RD, 2 + RD + RP, 2 + RD + 2 * RP, 2 + RD + 3 * RP};
    for (int i = 0; i < 6; i++) begin
      cyc(i >= 2, 1, 0); checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL hold_enter t=%0d got=%b exp=%b", t, obs(), exp_v); end
    end
    p0 = t + 1;
    for (int i = 0; i < 28; i++) begin
      cyc(1, i >= 20, 0);
      if (io.inc_hr === 1'b1) got.push_back(t - p0);
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL hold t=%0d got=%b exp=%b", t, obs(), exp_v); end
    end
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL hold_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] != want[i]) begin errors++; $display("FAIL hold_time idx=%0d got=%0d exp=%0d", i, got[i], want[i]); end
    end
  endtask
  task automatic test_simul();
    int ninc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(i >= 1, i >= 1, 0);
      ninc += io.inc_hr + io.inc_min; checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL simul t=%0d got=%b exp=%b", t, obs(), exp_v); end
    end
    checks++;
    if (io.mode !== 2'b10 || ninc != 0) begin errors++; $display("FAIL simul_sum mode=%b inc=%0d exp mode=10 inc=0", io.mode, ninc); end
  endtask
  task automatic test_random();
    bit km = 1, ki = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) km = ~km;
      if ($urandom_range(0, 5) == 0) ki = ~ki;
      cyc(km, ki, $urandom_range(0, 3) == 0);
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL random t=%0d got=%b exp=%b", t, obs(), exp_v); end
    end
  endtask
  task automatic test_mid_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(!(i == 0 || i == 1), i < 3, 0);
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL pre_reset t=%0d got=%b exp=%b", t, obs(), exp_v); end
    end
    #2 rst = 1; io.key_mode_n = 1; io.key_inc_n = 1;
    #1;
    checks++;
    if (obs() !== 8'h00) begin errors++; $display("FAIL async_reset got=%b exp=%b", obs(), 8'h00); end
    #14 rst = 0;
    @(negedge clk); model_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, i == 3);
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL post_reset t=%0d got=%b exp=%b", t, obs(), exp_v); end
    end
  endtask
  initial begin
    test_reset();
    test_mode_steps();
    test_inc_min();
    test_exit_run();
    test_hold();
    test_simul();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
